// File: rtl/ckt_bist_fsim.sv
// ckt_bist_fsim: LFSR-driven serial fault simulator for the six-input benchmark function
module ckt_bist_fsim #(
  parameter int PAT_COUNT = 63,
  parameter logic [5:0] SEED = 6'b000001,
  parameter int SIG_W = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
  parameter int CW = $clog2(PAT_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       fault_site,
  input  logic             fault_val,
  output logic             busy,
  output logic             done,
  output logic [5:0]       pattern,
  output logic             good_w,
  output logic             faulty_w,
  output logic [SIG_W-1:0] signature,
  output logic             detected,
  output logic [CW-1:0]    first_fail,
  output logic [CW-1:0]    fail_count
);
  localparam logic [5:0] SEED_EFF = (SEED == 6'd0) ? 6'd1 : SEED;
  localparam logic [CW-1:0] LAST = CW'(PAT_COUNT - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [5:0] lfsr, last_pat;
  logic [CW-1:0] cnt;
  logic [4:0] site_q;
  logic val_q, good, bad;
  function automatic logic frc(input logic [4:0] s, input logic v, input int k, input logic x);
    return (s == 5'(k)) ? v : x;
  endfunction
  function automatic logic eval(input logic [5:0] p, input logic [4:0] s, input logic v);
    logic [15:1] l;
    for (int i = 1; i <= 6; i++) l[i] = frc(s, v, i, p[6-i]);
    l[7]  = frc(s, v, 7, ~l[1]);
    l[8]  = frc(s, v, 8, l[4] | l[5]);
    l[9]  = frc(s, v, 9, l[8]);
    l[10] = frc(s, v, 10, l[8]);
    l[11] = frc(s, v, 11, l[7] & l[2]);
    l[12] = frc(s, v, 12, l[3] & l[9]);
    l[13] = frc(s, v, 13, l[10] | l[6]);
    l[14] = frc(s, v, 14, l[11] | l[12]);
    l[15] = frc(s, v, 15, l[14] & l[13]);
    return l[15];
  endfunction
  always_comb begin
    good = eval(lfsr, 5'd0, 1'b0);
    bad = eval(lfsr, site_q, val_q);
    state_n = (state == RUN) ? ((cnt == LAST) ? DONE : RUN) : (start ? RUN : state);
    busy = state == RUN;
    done = state == DONE;
    pattern = busy ? lfsr : last_pat;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr <= SEED_EFF;
      cnt <= '0;
      last_pat <= '0;
      good_w <= 1'b0;
      faulty_w <= 1'b0;
      signature <= '0;
      detected <= 1'b0;
      first_fail <= '0;
      fail_count <= '0;
      site_q <= '0;
      val_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state != RUN && start) begin
        lfsr <= SEED_EFF;
        cnt <= '0;
        signature <= '0;
        detected <= 1'b0;
        first_fail <= '0;
        fail_count <= '0;
        site_q <= fault_site;
        val_q <= fault_val;
      end else if (state == RUN) begin
        lfsr <= {lfsr[4:0], lfsr[5] ^ lfsr[4]};
        cnt <= cnt + 1'b1;
        last_pat <= lfsr;
        good_w <= good;
        faulty_w <= bad;
        signature <= {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? SIG_POLY : '0) ^ SIG_W'(bad);
        if (good != bad) begin
          if (!detected) first_fail <= cnt;
          detected <= 1'b1;
          if (!(&fail_count)) fail_count <= fail_count + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ckt_bist_fsim.sv
// tb_ckt_bist_fsim: directed checks of the fault simulator against an independent line-map model
module tb_ckt_bist_fsim;
  logic clk = 0, rst = 1, start = 0, fault_val = 0;
  logic [4:0] fault_site = 0;
  logic b1, d1, g1, f1, det1;
  logic [5:0] p1;
  logic [15:0] s1;
  logic [0:0] ff1, fc1;
  logic b63, d63, g63, f63, det63;
  logic [5:0] p63;
  logic [15:0] s63;
  logic [5:0] ff63, fc63;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  ckt_bist_fsim #(.PAT_COUNT(1)) u1 (.clk(clk), .rst(rst), .start(start), .fault_site(fault_site),
    .fault_val(fault_val), .busy(b1), .done(d1), .pattern(p1), .good_w(g1), .faulty_w(f1),
    .signature(s1), .detected(det1), .first_fail(ff1), .fail_count(fc1));
  ckt_bist_fsim u63 (.clk(clk), .rst(rst), .start(start), .fault_site(fault_site),
    .fault_val(fault_val), .busy(b63), .done(d63), .pattern(p63), .good_w(g63), .faulty_w(f63),
    .signature(s63), .detected(det63), .first_fail(ff63), .fail_count(fc63));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  function automatic logic mdl(input logic [5:0] p, input int s, input logic v);
    logic a, b, c, d, e, f, n7, n8, n9, n10, n11, n12, n13, n14;
    {a, b, c, d, e, f} = p;
    if (s == 1) a = v;
    if (s == 2) b = v;
    if (s == 3) c = v;
    if (s == 4) d = v;
    if (s == 5) e = v;
    if (s == 6) f = v;
    n7 = (s == 7) ? v : ~a;
    n8 = (s == 8) ? v : (d | e);
    n9 = (s == 9) ? v : n8;
    n10 = (s == 10) ? v : n8;
    n11 = (s == 11) ? v : (n7 & b);
    n12 = (s == 12) ? v : (c & n9);
    n13 = (s == 13) ? v : (n10 | f);
    n14 = (s == 14) ? v : (n11 | n12);
    return (s == 15) ? v : (n14 & n13);
  endfunction

  task automatic chk_reset63(input string tag);
    chk({tag, "_busy"}, b63, 0); chk({tag, "_done"}, d63, 0); chk({tag, "_pat"}, p63, 0);
    chk({tag, "_good"}, g63, 0); chk({tag, "_faulty"}, f63, 0); chk({tag, "_sig"}, s63, 0);
    chk({tag, "_det"}, det63, 0); chk({tag, "_ff"}, ff63, 0); chk({tag, "_fc"}, fc63, 0);
  endtask

  task automatic run63(input logic [4:0] s, input logic v, input int pulse_at, input int rst_at,
                       output logic det);
    logic [5:0] lf, lastp;
    logic [15:0] sig;
    logic g, f;
    int ff, fc;
    bit seen[64];
    lf = 6'd1; lastp = 0; sig = 0; det = 0; ff = 0; fc = 0;
    @(negedge clk);
    fault_site = s; fault_val = v; start = 1;
    @(negedge clk);
    start = 0; fault_site = ~s; fault_val = ~v;
    chk("run_done_clr", d63, 0);
    for (int i = 0; i < 63; i++) begin
      start = (i == pulse_at);
      if (i == rst_at) begin
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk_reset63("abort");
        return;
      end
      chk("busy", b63, 1);
      chk("pattern", p63, lf);
      chk("unique", seen[lf], 0);
      seen[lf] = 1;
      g = mdl(lf, 0, 0);
      f = mdl(lf, s, v);
      if (f != g) begin
        if (!det) ff = i;
        det = 1;
        if (fc < 63) fc++;
      end
      sig = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0) ^ {15'b0, f};
      @(posedge clk); #1;
      chk("good_w", g63, g);
      chk("faulty_w", f63, f);
      if (v && lf[2:1] == 0 && lf[3] && s == 9) chk("branch9", f63, lf[0]);
      if (v && lf[2:1] == 0 && lf[3] && s == 10) chk("branch10", f63, ~lf[5] & lf[4]);
      lastp = lf;
      lf = {lf[4:0], lf[5] ^ lf[4]};
      @(negedge clk);
    end
    start = 0;
    chk("end_busy", b63, 0); chk("end_done", d63, 1); chk("end_pat", p63, lastp);
    chk("end_sig", s63, sig); chk("end_det", det63, det);
    chk("end_ff", ff63, ff); chk("end_fc", fc63, fc);
    repeat (2) @(negedge clk);
    chk("hold_done", d63, 1); chk("hold_sig", s63, sig);
  endtask

  typedef struct { logic [4:0] site; logic val; logic det; } vec_t;
  vec_t tbl[9];
  logic det;
  logic [5:0] seq[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl = '{'{0, 0, 0}, '{7, 0, 1}, '{9, 1, 1}, '{10, 1, 1}, '{15, 1, 1},
            '{15, 0, 1}, '{20, 1, 0}, '{8, 0, 1}, '{1, 1, 1}};
    seq = '{6'o01, 6'o02, 6'o04, 6'o10, 6'o20, 6'o41, 6'o03};
    repeat (2) @(negedge clk);
    rst = 0;
    chk_reset63("reset");
    chk("r1_done", d1, 0);
    // single-pattern runs
    fault_site = 0; fault_val = 0; start = 1;
    @(negedge clk);
    start = 0; fault_site = 15; fault_val = 1;
    chk("p1_busy", b1, 1); chk("p1_pat_run", p1, 6'o01);
    @(negedge clk);
    chk("p1_busy_lo", b1, 0); chk("p1_done", d1, 1); chk("p1_pat", p1, 6'o01);
    chk("p1_good", g1, 0); chk("p1_faulty", f1, 0); chk("p1_sig", s1, 0);
    chk("p1_det", det1, 0); chk("p1_fc", fc1, 0);
    fault_site = 15; fault_val = 1; start = 1;
    @(negedge clk);
    start = 0; fault_site = 0; fault_val = 0;
    @(negedge clk);
    chk("s15_done", d1, 1); chk("s15_good", g1, 0); chk("s15_faulty", f1, 1);
    chk("s15_det", det1, 1); chk("s15_ff", ff1, 0); chk("s15_fc", fc1, 1); chk("s15_sig", s1, 16'h0001);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_reset63("rst2");
    // LFSR order at the start of a fault-free run
    fault_site = 0; start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 7; i++) begin
      chk("lfsr_seq", p63, seq[i]);
      @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 9; i++) begin
      run63(tbl[i].site, tbl[i].val, -1, -1, det);
      chk("tbl_det", det63, tbl[i].det);
    end
    run63(7, 0, -1, -1, det);
    run63(7, 0, 10, -1, det);
    run63(7, 0, -1, 20, det);
    run63(9, 1, -1, -1, det);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
